// File: rtl/l2_set_ctrl_if.sv
// Request, set-storage, bus and snoop-response signals of the L2 set controller.
// The slave modport is the controller; the master side is the surrounding cache/bus.
interface l2_set_ctrl_if #(
    parameter int ASSOC = 8,
    parameter int TAG_W = 12,
    parameter int IDX_W = 14,
    parameter int LRU_W = $clog2(ASSOC)
);
    localparam int SET_W = ASSOC * (TAG_W + 2 + LRU_W);

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_index;

    logic             set_rd_en;
    logic [IDX_W-1:0] set_rd_index;
    logic [SET_W-1:0] set_rd_data;
    logic             set_wr_en;
    logic [IDX_W-1:0] set_wr_index;
    logic [SET_W-1:0] set_wr_data;

    logic             bus_valid;
    logic [2:0]       bus_op;
    logic [TAG_W-1:0] bus_tag;
    logic [IDX_W-1:0] bus_index;
    logic             bus_done;
    logic [1:0]       bus_snoop;

    logic             snp_resp_valid;
    logic [1:0]       snp_resp;
    logic             done;
    logic             hit;

    modport slave (
        input  req_valid, req_op, req_tag, req_index, set_rd_data, bus_done, bus_snoop,
        output req_ready, set_rd_en, set_rd_index, set_wr_en, set_wr_index, set_wr_data,
               bus_valid, bus_op, bus_tag, bus_index, snp_resp_valid, snp_resp, done, hit
    );

    modport master (
        output req_valid, req_op, req_tag, req_index, set_rd_data, bus_done, bus_snoop,
        input  req_ready, set_rd_en, set_rd_index, set_wr_en, set_wr_index, set_wr_data,
               bus_valid, bus_op, bus_tag, bus_index, snp_resp_valid, snp_resp, done, hit
    );
endinterface

// File: rtl/l2_set_ctrl.sv
// L2 set control stage: reads one set, does tag compare / victim choice, runs bus ops,
// applies MESI and true-LRU (ru_num) updates and writes the set back. One request at a time.
module l2_set_ctrl #(
    parameter int ASSOC = 8,
    parameter int TAG_W = 12,
    parameter int IDX_W = 14,
    parameter int LRU_W = $clog2(ASSOC)
) (
    input logic        clk,
    input logic        rst,
    l2_set_ctrl_if.slave io
);
    localparam int EW = TAG_W + 2 + LRU_W;

    localparam logic [1:0] M_INV  = 2'd0;
    localparam logic [1:0] M_MOD  = 2'd1;
    localparam logic [1:0] M_EXCL = 2'd2;
    localparam logic [1:0] M_SHRD = 2'd3;

    localparam logic [2:0] B_READ  = 3'd1;
    localparam logic [2:0] B_WRITE = 3'd2;
    localparam logic [2:0] B_INVAL = 3'd3;
    localparam logic [2:0] B_RWIM  = 3'd4;

    localparam logic [1:0] SN_NOTHIT = 2'd0;
    localparam logic [1:0] SN_HIT    = 2'd1;
    localparam logic [1:0] SN_HITM   = 2'd2;

    localparam logic [LRU_W-1:0] RU_MAX = LRU_W'(ASSOC - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_WB, S_BUSOP, S_UPD} state_t;

    state_t state, state_nx;

    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;

    logic [ASSOC-1:0][TAG_W-1:0] rd_tag, set_tag_q, wr_tag;
    logic [ASSOC-1:0][1:0]       rd_mesi, set_mesi_q, wr_mesi;
    logic [ASSOC-1:0][LRU_W-1:0] rd_ru, set_ru_q, wr_ru;
    logic [ASSOC-1:0]            way_match;

    logic             hit_c, inv_found;
    logic [LRU_W-1:0] hit_way_c, inv_way_c, lru_way_c, vic_way_c;
    logic             hit_q;
    logic [LRU_W-1:0] way_q;
    logic [1:0]       snoop_q;

    logic             bus_ld;
    logic [2:0]       bus_op_q, bus_op_d;
    logic [TAG_W-1:0] bus_tag_q, bus_tag_d;
    logic             snp_vld_c;
    logic [1:0]       snp_c;

    // Per-way unpack of the read set, tag compare, and repack of the updated set.
    for (genvar w = 0; w < ASSOC; w++) begin : g_way
        assign {rd_tag[w], rd_mesi[w], rd_ru[w]} = io.set_rd_data[w*EW +: EW];
        assign way_match[w] = (rd_mesi[w] != M_INV) && (rd_tag[w] == tag_q);
        assign io.set_wr_data[w*EW +: EW] = io.set_wr_en ? {wr_tag[w], wr_mesi[w], wr_ru[w]} : '0;
    end

    // Descending scans so the lowest matching way wins.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        inv_found = 1'b0;
        inv_way_c = '0;
        lru_way_c = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit_c     = 1'b1;
                hit_way_c = LRU_W'(w);
            end
            if (rd_mesi[w] == M_INV) begin
                inv_found = 1'b1;
                inv_way_c = LRU_W'(w);
            end
            if (rd_ru[w] == RU_MAX) lru_way_c = LRU_W'(w);
        end
        vic_way_c = inv_found ? inv_way_c : lru_way_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        bus_ld    = 1'b0;
        bus_op_d  = bus_op_q;
        bus_tag_d = bus_tag_q;
        snp_vld_c = 1'b0;
        snp_c     = SN_NOTHIT;
        case (state)
            S_IDLE: if (io.req_valid) state_nx = S_RD;
            S_RD:   state_nx = S_CMP;
            S_CMP: begin
                state_nx = S_UPD;
                if (op_q[1]) begin
                    snp_vld_c = 1'b1;
                    if (hit_c && rd_mesi[hit_way_c] == M_MOD) begin
                        snp_c     = SN_HITM;
                        state_nx  = S_WB;
                        bus_ld    = 1'b1;
                        bus_op_d  = B_WRITE;
                        bus_tag_d = tag_q;
                    end else begin
                        snp_c = hit_c ? SN_HIT : SN_NOTHIT;
                    end
                end else if (hit_c) begin
                    if (op_q[0] && rd_mesi[hit_way_c] == M_SHRD) begin
                        state_nx  = S_BUSOP;
                        bus_ld    = 1'b1;
                        bus_op_d  = B_INVAL;
                        bus_tag_d = tag_q;
                    end
                end else if (rd_mesi[vic_way_c] == M_MOD) begin
                    // Dirty victim goes out under its own tag before the fill.
                    state_nx  = S_WB;
                    bus_ld    = 1'b1;
                    bus_op_d  = B_WRITE;
                    bus_tag_d = rd_tag[vic_way_c];
                end else begin
                    state_nx  = S_BUSOP;
                    bus_ld    = 1'b1;
                    bus_op_d  = op_q[0] ? B_RWIM : B_READ;
                    bus_tag_d = tag_q;
                end
            end
            S_WB: begin
                if (io.bus_done) begin
                    if (op_q[1]) begin
                        state_nx = S_UPD;
                    end else begin
                        state_nx  = S_BUSOP;
                        bus_ld    = 1'b1;
                        bus_op_d  = op_q[0] ? B_RWIM : B_READ;
                        bus_tag_d = tag_q;
                    end
                end
            end
            S_BUSOP: if (io.bus_done) state_nx = S_UPD;
            S_UPD:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            tag_q      <= '0;
            idx_q      <= '0;
            set_tag_q  <= '0;
            set_mesi_q <= '0;
            set_ru_q   <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            snoop_q    <= '0;
            bus_op_q   <= '0;
            bus_tag_q  <= '0;
        end else begin
            if (state == S_IDLE && io.req_valid) begin
                op_q  <= io.req_op;
                tag_q <= io.req_tag;
                idx_q <= io.req_index;
            end
            if (state == S_CMP) begin
                set_tag_q  <= rd_tag;
                set_mesi_q <= rd_mesi;
                set_ru_q   <= rd_ru;
                hit_q      <= hit_c;
                way_q      <= hit_c ? hit_way_c : vic_way_c;
            end
            if (bus_ld) begin
                bus_op_q  <= bus_op_d;
                bus_tag_q <= bus_tag_d;
            end
            if (state == S_BUSOP && io.bus_done) snoop_q <= io.bus_snoop;
        end
    end

    // Write-back image: MESI per op, fill tag on proc miss, ru_num aging on proc only.
    always_comb begin
        wr_tag  = set_tag_q;
        wr_mesi = set_mesi_q;
        wr_ru   = set_ru_q;
        if (op_q[1]) begin
            if (hit_q) wr_mesi[way_q] = op_q[0] ? M_INV : M_SHRD;
        end else begin
            if (!hit_q) wr_tag[way_q] = tag_q;
            if (op_q[0])
                wr_mesi[way_q] = M_MOD;
            else if (!hit_q)
                wr_mesi[way_q] = (snoop_q == SN_HIT || snoop_q == SN_HITM) ? M_SHRD : M_EXCL;
            for (int w = 0; w < ASSOC; w++) begin
                if (LRU_W'(w) == way_q)
                    wr_ru[w] = '0;
                else if (set_ru_q[w] < set_ru_q[way_q])
                    wr_ru[w] = set_ru_q[w] + LRU_W'(1);
            end
        end
    end

    assign io.req_ready      = (state == S_IDLE);
    assign io.set_rd_en      = (state == S_RD);
    assign io.set_rd_index   = idx_q;
    assign io.set_wr_en      = (state == S_UPD);
    assign io.set_wr_index   = idx_q;
    assign io.bus_valid      = (state == S_WB) || (state == S_BUSOP);
    assign io.bus_op         = bus_op_q;
    assign io.bus_tag        = bus_tag_q;
    assign io.bus_index      = idx_q;
    assign io.snp_resp_valid = snp_vld_c;
    assign io.snp_resp       = snp_c;
    assign io.done           = (state == S_UPD);
    assign io.hit            = (state == S_UPD) && hit_q;

endmodule

// File: tb/tb_l2_set_ctrl.sv
// Bench for l2_set_ctrl: behavioural set storage and bus agent, directed scenarios
// plus randomized requests checked against a spec-level reference model.
module tb_l2_set_ctrl;
  localparam int EW = 17;
  localparam int SW = 8 * EW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_set_ctrl_if #(.ASSOC(8), .TAG_W(12), .IDX_W(14)) io();
  l2_set_ctrl #(.ASSOC(8), .TAG_W(12), .IDX_W(14)) dut (.clk(clk), .rst(rst), .io(io));

  int n_cmp = 0;
  int n_bad = 0;

  logic [SW-1:0] mem [16];
  logic [SW-1:0] rd_q = '0;
  int            wr_cnt = 0;
  always @(posedge clk) if (io.set_rd_en) rd_q <= mem[io.set_rd_index[3:0]];
  always @(posedge clk) if (io.set_wr_en) wr_cnt <= wr_cnt + 1;
  assign io.set_rd_data = rd_q;

  logic [14:0] bus_log [$];
  int          snp_log [$];
  bit          bus_hold   = 1'b0;
  logic [1:0]  snoop_plan = 2'd0;

  // Bus agent: random wait per op, bus_snoop is junk except in the done cycle.
  initial begin
    int wc;
    wc = 0;
    io.bus_done  = 1'b0;
    io.bus_snoop = 2'd0;
    forever begin
      @(negedge clk);
      io.bus_done  = 1'b0;
      io.bus_snoop = 2'($urandom);
      if (io.snp_resp_valid) snp_log.push_back(int'(io.snp_resp));
      if (io.bus_valid && !bus_hold && !rst) begin
        if (wc == 0) begin
          bus_log.push_back({io.bus_op, io.bus_tag});
          io.bus_done  = 1'b1;
          io.bus_snoop = snoop_plan;
          wc = $urandom_range(0, 3);
        end else begin
          wc--;
        end
      end
    end
  end

  function automatic logic [SW-1:0] put(input logic [SW-1:0] s, input int w,
                                        input logic [11:0] t, input logic [1:0] m, input int r);
    s[w*EW +: EW] = {t, m, 3'(r)};
    return s;
  endfunction

  task automatic gen_set(output logic [SW-1:0] s);
    int p[8];
    for (int i = 0; i < 8; i++) p[i] = i;
    for (int i = 7; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    s = '0;
    for (int i = 0; i < 8; i++)
      s = put(s, i, {9'($urandom), 3'(i)}, 2'($urandom), p[i]);
  endtask

  // Reference: hit/victim rules, MESI table and LRU aging, expressed on plain arrays.
  task automatic model(input logic [SW-1:0] s, input logic [1:0] op, input logic [11:0] tag,
                       input logic [1:0] snp, output logic [SW-1:0] ns, output bit h,
                       output int nb, output logic [14:0] b0, output logic [14:0] b1,
                       output int sr);
    logic [11:0] t[8];
    logic [1:0]  m[8];
    int          r[8];
    int          hw, v, w, c;
    for (int i = 0; i < 8; i++) begin
      logic [EW-1:0] e;
      e = s[i*EW +: EW];
      t[i] = e[16:5];
      m[i] = e[4:3];
      r[i] = int'(e[2:0]);
    end
    hw = -1;
    for (int i = 7; i >= 0; i--) if (m[i] != 2'd0 && t[i] == tag) hw = i;
    v = 0;
    for (int i = 7; i >= 0; i--) if (r[i] == 7) v = i;
    for (int i = 7; i >= 0; i--) if (m[i] == 2'd0) v = i;
    h  = (hw >= 0);
    w  = h ? hw : v;
    nb = 0; b0 = '0; b1 = '0; sr = -1;
    if (op >= 2'd2) begin
      if (h && m[w] == 2'd1) begin
        sr = 2; nb = 1; b0 = {3'd2, tag};
      end else begin
        sr = h ? 1 : 0;
      end
      if (h) m[w] = (op == 2'd2) ? 2'd3 : 2'd0;
    end else begin
      if (!h) begin
        if (m[v] == 2'd1) begin nb = 1; b0 = {3'd2, t[v]}; end
        if (nb == 0) b0 = {(op == 2'd1) ? 3'd4 : 3'd1, tag};
        else         b1 = {(op == 2'd1) ? 3'd4 : 3'd1, tag};
        nb++;
        t[w] = tag;
        m[w] = (op == 2'd1) ? 2'd1 : ((snp != 2'd0) ? 2'd3 : 2'd2);
      end else begin
        if (op == 2'd1 && m[w] == 2'd3) begin nb = 1; b0 = {3'd3, tag}; end
        if (op == 2'd1) m[w] = 2'd1;
      end
      c = r[w];
      for (int i = 0; i < 8; i++) begin
        if (i == w)       r[i] = 0;
        else if (r[i] < c) r[i] = r[i] + 1;
      end
    end
    ns = '0;
    for (int i = 0; i < 8; i++) ns = put(ns, i, t[i], m[i], r[i]);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [11:0] tag, input int idx,
                         input logic [1:0] snp, output bit got, output int lat, output bit h,
                         output bit wr, output logic [SW-1:0] wd);
    bus_log.delete();
    snp_log.delete();
    snoop_plan = snp;
    @(negedge clk);
    io.req_valid = 1'b1; io.req_op = op; io.req_tag = tag; io.req_index = 14'(idx);
    @(posedge clk);
    @(negedge clk);
    io.req_valid = 1'b0;
    got = 1'b0; lat = 0; h = 1'b0; wr = 1'b0; wd = '0;
    for (int c = 1; c <= 200; c++) begin
      if (io.done) begin
        got = 1'b1; lat = c; h = io.hit; wr = io.set_wr_en; wd = io.set_wr_data;
        break;
      end
      @(negedge clk);
    end
    if (got && wr) mem[idx] = wd;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (io.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", io.req_ready); end
    n_cmp++; if ({io.set_rd_en, io.set_wr_en, io.bus_valid, io.done, io.hit, io.snp_resp_valid} !== 6'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 000000",
        {io.set_rd_en, io.set_wr_en, io.bus_valid, io.done, io.hit, io.snp_resp_valid}); end
    n_cmp++; if ({io.bus_op, io.bus_tag, io.set_wr_data} !== '0) begin
      n_bad++; $display("FAIL reset_data: bus_op %0d bus_tag %0h nonzero", io.bus_op, io.bus_tag); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_hit;
    logic [SW-1:0] s, exp, wd;
    bit got, h, wr; int lat;
    int exp_ru[8] = '{1, 2, 0, 3, 4, 5, 6, 7};
    s = '0; exp = '0;
    for (int w = 0; w < 8; w++) begin
      s   = put(s,   w, 12'(12'h100 + w), (w == 2) ? 2'd2 : 2'd3, w);
      exp = put(exp, w, 12'(12'h100 + w), (w == 2) ? 2'd2 : 2'd3, exp_ru[w]);
    end
    mem[1] = s;
    run_req(2'd0, 12'h102, 1, 2'd0, got, lat, h, wr, wd);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rdhit_timeout: no done"); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rdhit_latency: got %0d want 3", lat); end
    n_cmp++; if (h !== 1'b1 || wr !== 1'b1) begin n_bad++; $display("FAIL rdhit_hit_wr: got %b%b want 11", h, wr); end
    n_cmp++; if (wd !== exp) begin n_bad++; $display("FAIL rdhit_set: got %h want %h", wd, exp); end
    n_cmp++; if (bus_log.size() !== 0) begin n_bad++; $display("FAIL rdhit_bus: got %0d ops want 0", bus_log.size()); end
  endtask

  task automatic test_miss_dirty_victim;
    logic [SW-1:0] s, exp, wd;
    bit got, h, wr; int lat;
    s = '0; exp = '0;
    for (int w = 0; w < 8; w++) begin
      s = put(s, w, 12'(12'h200 + w), (w == 7) ? 2'd1 : 2'd3, w);
      exp = (w == 7) ? put(exp, w, 12'hABC, 2'd3, 0) : put(exp, w, 12'(12'h200 + w), 2'd3, w + 1);
    end
    mem[2] = s;
    run_req(2'd0, 12'hABC, 2, 2'd1, got, lat, h, wr, wd);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL miss_timeout: no done"); end
    n_cmp++; if (bus_log.size() !== 2) begin n_bad++; $display("FAIL miss_busn: got %0d want 2", bus_log.size()); end
    else begin
      n_cmp++; if (bus_log[0] !== {3'd2, 12'h207}) begin n_bad++; $display("FAIL miss_wb: got %h want %h", bus_log[0], {3'd2, 12'h207}); end
      n_cmp++; if (bus_log[1] !== {3'd1, 12'hABC}) begin n_bad++; $display("FAIL miss_rd: got %h want %h", bus_log[1], {3'd1, 12'hABC}); end
    end
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL miss_hit: got %b want 0", h); end
    n_cmp++; if (wd !== exp) begin n_bad++; $display("FAIL miss_set: got %h want %h", wd, exp); end
  endtask

  task automatic test_write_shared;
    logic [SW-1:0] s, exp, wd;
    bit got, h, wr; int lat;
    s = '0; exp = '0;
    for (int w = 0; w < 8; w++) begin
      s = put(s, w, 12'(12'h300 + w), (w == 4) ? 2'd3 : 2'd2, w);
      exp = put(exp, w, 12'(12'h300 + w), (w == 4) ? 2'd1 : 2'd2, (w == 4) ? 0 : ((w < 4) ? w + 1 : w));
    end
    mem[3] = s;
    run_req(2'd1, 12'h304, 3, 2'd0, got, lat, h, wr, wd);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL wrsh_timeout: no done"); end
    n_cmp++; if (bus_log.size() !== 1 || bus_log[0] !== {3'd3, 12'h304}) begin
      n_bad++; $display("FAIL wrsh_inval: got %0d ops first %h want 1 op %h", bus_log.size(),
        (bus_log.size() > 0) ? bus_log[0] : 15'h0, {3'd3, 12'h304}); end
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL wrsh_hit: got %b want 1", h); end
    n_cmp++; if (wd !== exp) begin n_bad++; $display("FAIL wrsh_set: got %h want %h", wd, exp); end
  endtask

  task automatic test_snoop_hitm;
    logic [SW-1:0] s, exp, wd;
    bit got, h, wr; int lat;
    s = '0; exp = '0;
    for (int w = 0; w < 8; w++) begin
      s   = put(s,   w, 12'(12'h450 + w), (w == 5) ? 2'd1 : 2'd3, 7 - w);
      exp = put(exp, w, 12'(12'h450 + w), 2'd3, 7 - w);
    end
    mem[4] = s;
    run_req(2'd2, 12'h455, 4, 2'd0, got, lat, h, wr, wd);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL snphm_timeout: no done"); end
    n_cmp++; if (snp_log.size() !== 1 || snp_log[0] !== 2) begin
      n_bad++; $display("FAIL snphm_resp: got %0d pulses first %0d want 1 pulse 2", snp_log.size(),
        (snp_log.size() > 0) ? snp_log[0] : -1); end
    n_cmp++; if (bus_log.size() !== 1 || bus_log[0] !== {3'd2, 12'h455}) begin
      n_bad++; $display("FAIL snphm_wb: got %0d ops want 1 WRITE 455", bus_log.size()); end
    n_cmp++; if (wd !== exp) begin n_bad++; $display("FAIL snphm_set: got %h want %h", wd, exp); end
  endtask

  task automatic test_snoop_miss;
    logic [SW-1:0] s, wd;
    bit got, h, wr; int lat;
    s = '0;
    for (int w = 0; w < 8; w++) s = put(s, w, 12'(12'h500 + w), 2'(w), 7 - w);
    mem[5] = s;
    run_req(2'd3, 12'hFFF, 5, 2'd0, got, lat, h, wr, wd);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL snpmiss_timeout: no done"); end
    n_cmp++; if (snp_log.size() !== 1 || snp_log[0] !== 0) begin
      n_bad++; $display("FAIL snpmiss_resp: got %0d pulses want 1 pulse NOTHIT", snp_log.size()); end
    n_cmp++; if (bus_log.size() !== 0) begin n_bad++; $display("FAIL snpmiss_bus: got %0d ops want 0", bus_log.size()); end
    n_cmp++; if (wr !== 1'b1 || wd !== s || h !== 1'b0) begin
      n_bad++; $display("FAIL snpmiss_set: got wr %b hit %b data %h want 1 0 %h", wr, h, wd, s); end
  endtask

  task automatic test_reset_in_busop;
    logic [SW-1:0] s, ns, wd, b0, b1;
    bit got, h, wr, eh, seen; int lat, nb, sr, wc0;
    logic [14:0] e0, e1;
    s = '0;
    for (int w = 0; w < 8; w++) s = put(s, w, 12'(12'h600 + w), 2'd3, w);
    mem[6] = s;
    bus_hold = 1'b1;
    @(negedge clk);
    io.req_valid = 1'b1; io.req_op = 2'd0; io.req_tag = 12'hEEE; io.req_index = 14'd6;
    @(posedge clk);
    @(negedge clk);
    io.req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (io.bus_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!seen || io.bus_op !== 3'd1) begin n_bad++; $display("FAIL rstbus_reach: seen %b op %0d want 1 1", seen, io.bus_op); end
    wc0 = wr_cnt;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({io.bus_valid, io.set_wr_en, io.done, io.req_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rstbus_clear: got %b want 0001", {io.bus_valid, io.set_wr_en, io.done, io.req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (wr_cnt !== wc0) begin n_bad++; $display("FAIL rstbus_nowrite: got %0d writes want %0d", wr_cnt, wc0); end
    bus_hold = 1'b0;
    model(mem[6], 2'd0, 12'hEEE, 2'd0, ns, eh, nb, e0, e1, sr);
    run_req(2'd0, 12'hEEE, 6, 2'd0, got, lat, h, wr, wd);
    n_cmp++; if (!got || wd !== ns || h !== eh) begin
      n_bad++; $display("FAIL rstbus_after: got done %b hit %b data %h want 1 %b %h", got, h, wd, eh, ns); end
    b0 = '0; b1 = '0;
  endtask

  task automatic test_random;
    logic [SW-1:0] s, ns, wd;
    logic [1:0] op, snp;
    logic [11:0] tag;
    logic [14:0] e0, e1;
    bit got, h, wr, eh; int lat, nb, sr, idx, w;
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin gen_set(s); mem[idx] = s; end
      s   = mem[idx];
      op  = 2'($urandom);
      snp = 2'($urandom_range(0, 2));
      w   = $urandom_range(0, 7);
      tag = ($urandom_range(0, 1) == 1) ? s[w*EW+5 +: 12] : 12'($urandom);
      model(s, op, tag, snp, ns, eh, nb, e0, e1, sr);
      run_req(op, tag, idx, snp, got, lat, h, wr, wd);
      n_cmp++; if (!got || !wr) begin n_bad++; $display("FAIL rnd_done[%0d]: done %b wr %b want 1 1", n, got, wr); end
      n_cmp++; if (h !== eh) begin n_bad++; $display("FAIL rnd_hit[%0d]: got %b want %b", n, h, eh); end
      n_cmp++; if (wd !== ns) begin n_bad++; $display("FAIL rnd_set[%0d]: got %h want %h", n, wd, ns); end
      n_cmp++; if (bus_log.size() !== nb) begin n_bad++; $display("FAIL rnd_busn[%0d]: got %0d want %0d", n, bus_log.size(), nb); end
      else begin
        if (nb > 0) begin n_cmp++; if (bus_log[0] !== e0) begin n_bad++; $display("FAIL rnd_bus0[%0d]: got %h want %h", n, bus_log[0], e0); end end
        if (nb > 1) begin n_cmp++; if (bus_log[1] !== e1) begin n_bad++; $display("FAIL rnd_bus1[%0d]: got %h want %h", n, bus_log[1], e1); end end
      end
      n_cmp++;
      if (sr < 0) begin
        if (snp_log.size() !== 0) begin n_bad++; $display("FAIL rnd_snp[%0d]: got %0d pulses want 0", n, snp_log.size()); end
      end else if (snp_log.size() !== 1 || snp_log[0] !== sr) begin
        n_bad++; $display("FAIL rnd_snp[%0d]: got %0d pulses first %0d want 1 pulse %0d", n, snp_log.size(),
          (snp_log.size() > 0) ? snp_log[0] : -1, sr);
      end
    end
  endtask

  initial begin
    io.req_valid = 1'b0;
    io.req_op    = 2'd0;
    io.req_tag   = '0;
    io.req_index = '0;
    for (int i = 0; i < 16; i++) begin
      logic [SW-1:0] s;
      gen_set(s);
      mem[i] = s;
    end
    test_reset();
    test_read_hit();
    test_miss_dirty_victim();
    test_write_shared();
    test_snoop_hitm();
    test_snoop_miss();
    test_reset_in_busop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/l2_set_ctrl.md
Name: l2_set_ctrl

Overview:
- Per-request control stage directly downstream of the L2 set storage.
- Reads one set; does tag compare, hit/miss and victim selection; issues bus ops; applies MESI and true-LRU (ru_num counter) updates; writes the set back.
- Serves both processor requests and snooped bus requests, one request at a time.

Parameters:
ASSOC, 8, ways per set (power of 2)
TAG_W, 12, tag width
IDX_W, 14, set index width
LRU_W, $clog2(ASSOC), ru_num width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_op  in  2  0=proc read, 1=proc write, 2=snoop read, 3=snoop RWIM/invalidate
req_tag  in  TAG_W  request tag
req_index  in  IDX_W  request set index
set_rd_en  out  1  set read strobe
set_rd_index  out  IDX_W  set to read
set_rd_data  in  ASSOC*(TAG_W+2+LRU_W)  set contents, valid 1 cycle after set_rd_en; per way {tag, mesi, ru_num}; way 0 in LSBs
set_wr_en  out  1  set write strobe
set_wr_index  out  IDX_W  set to write
set_wr_data  out  same as set_rd_data  updated set
bus_valid  out  1  held high until bus_done
bus_op  out  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM
bus_tag  out  TAG_W  bus op tag
bus_index  out  IDX_W  bus op index
bus_done  in  1  bus op complete
bus_snoop  in  2  snoop result for own READ: 0=NOTHIT, 1=HIT, 2=HITM; sampled with bus_done
snp_resp_valid  out  1  one-cycle pulse
snp_resp  out  2  0=NOTHIT, 1=HIT, 2=HITM
done  out  1  one-cycle completion pulse
hit  out  1  valid with done

Behaviour:
- MESI encoding: INV=0, MOD=1, EXCL=2, SHRD=3.
- Reset (async): FSM to IDLE; all outputs 0 except req_ready=1. No set write is issued for an aborted request.
- FSM states: IDLE, RD, CMP, WB, BUSOP, UPD.
- IDLE: req_valid && req_ready captures op/tag/index -> RD.
- RD: set_rd_en=1 for one cycle -> CMP.
- CMP: hit = a way with tag match and mesi!=INV (at most one).
  - Victim = lowest-index INV way; otherwise lowest-index way with ru_num==ASSOC-1.
  - Proc miss with MOD victim -> WB (bus WRITE, victim's tag).
  - Snoop hit on MOD -> snp_resp=HITM pulse, then WB (bus WRITE).
  - Other snoop -> snp_resp pulse (HIT if hit, else NOTHIT) -> UPD.
  - Proc write hit on SHRD -> BUSOP INVALIDATE.
  - Proc read miss -> BUSOP READ; proc write miss -> BUSOP RWIM.
  - All remaining cases -> UPD.
- WB: hold bus_valid until bus_done. Then proc -> BUSOP (READ or RWIM); snoop -> UPD.
- BUSOP: hold bus_valid until bus_done; latch bus_snoop -> UPD.
- bus_done outside WB/BUSOP is ignored.
- UPD: set_wr_en=1 for one cycle; done=1 and hit output in the same cycle -> IDLE.
- MESI next state:
  - Proc read hit: unchanged. Proc read miss: SHRD if bus_snoop is HIT or HITM, else EXCL.
  - Proc write hit or miss: MOD.
  - Snoop read on hit: SHRD. Snoop RWIM on hit: INV. Snoop miss: no change.
- On fill, the victim way's tag is replaced by req_tag.
- LRU (proc requests only; snoops leave ru_num unchanged): accessed or filled way w with old count c. Every way with ru_num<c increments; way w becomes 0. ru_num values remain a permutation of 0..ASSOC-1.
- Latency: proc read hit or hit-write on MOD/EXCL gives done 3 cycles after accept. Bus states add the bus wait time plus 1 cycle each.

Test Plan:
1. Reset: set ru_num=way index. Read hit way 2 (EXCL) -> done at +3, hit=1, mesi stays EXCL, ru_num becomes {1,2,0,3,4,5,6,7}.
2. Read miss, all ways valid, way 7 MOD with ru_num=7 -> bus WRITE with the old tag, then READ; bus_snoop=HIT -> way 7 holds the new tag in SHRD with ru_num=0, all other ru_num incremented.
3. Write hit on SHRD -> bus INVALIDATE; after bus_done the way is MOD with hit=1.
4. Snoop read hit on MOD -> snp_resp=HITM, bus WRITE, way goes to SHRD, ru_num unchanged.
5. Snoop RWIM miss -> snp_resp=NOTHIT, no bus op, set written back unchanged.
6. Assert rst while in BUSOP -> outputs clear immediately, no set_wr_en. A new request after reset completes normally.
